// File: rtl/sf_ctrl_if.sv
// Bundle between the snoop-filter controller and its surroundings.
// slave  : the controller (sf_ctrl).
// master : the environment -- SLC request source, snoop-response/evict
//          source, snoop-filter SRAM read data, and the snoop dispatcher
//          consuming lookup results.
// Signals: req_* (SLC lookup handshake), upd_* (presence-vector updates),
//          arr_* (single-port array access), lkp_* (lookup results),
//          init_done (array clear complete).
interface sf_ctrl_if #(
    parameter int unsigned SET_W  = 7,
    parameter int unsigned TAG_W  = 35,
    parameter int unsigned NUM_RN = 4,
    parameter int unsigned RN_W   = 2
);
    logic              req_valid;
    logic              req_ready;
    logic [SET_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;
    logic [RN_W-1:0]   req_src;
    logic              req_unique;

    logic              upd_valid;
    logic              upd_ready;
    logic [SET_W-1:0]  upd_set;
    logic [TAG_W-1:0]  upd_tag;
    logic [RN_W-1:0]   upd_src;
    logic              upd_inval;

    logic              arr_en;
    logic              arr_we;
    logic [SET_W-1:0]  arr_set;
    logic [TAG_W-1:0]  arr_wtag;
    logic [NUM_RN-1:0] arr_wvec;
    logic [TAG_W-1:0]  arr_rtag;
    logic [NUM_RN-1:0] arr_rvec;

    logic              lkp_valid;
    logic              lkp_hit;
    logic [NUM_RN-1:0] lkp_snp_vec;
    logic              lkp_evict;
    logic [TAG_W-1:0]  lkp_evict_tag;
    logic [NUM_RN-1:0] lkp_evict_vec;

    logic              init_done;

    modport slave (
        input  req_valid, req_set, req_tag, req_src, req_unique,
        output req_ready,
        input  upd_valid, upd_set, upd_tag, upd_src, upd_inval,
        output upd_ready,
        output arr_en, arr_we, arr_set, arr_wtag, arr_wvec,
        input  arr_rtag, arr_rvec,
        output lkp_valid, lkp_hit, lkp_snp_vec, lkp_evict, lkp_evict_tag, lkp_evict_vec,
        output init_done
    );

    modport master (
        output req_valid, req_set, req_tag, req_src, req_unique,
        input  req_ready,
        output upd_valid, upd_set, upd_tag, upd_src, upd_inval,
        input  upd_ready,
        input  arr_en, arr_we, arr_set, arr_wtag, arr_wvec,
        output arr_rtag, arr_rvec,
        input  lkp_valid, lkp_hit, lkp_snp_vec, lkp_evict, lkp_evict_tag, lkp_evict_vec,
        input  init_done
    );
endinterface

// File: rtl/sf_ctrl.sv
// HN-F snoop-filter sequencing controller.
// Clears the 128-set array after reset, then arbitrates SLC lookups against
// snoop-response/eviction updates; each accepted operation is a 3-cycle
// read-modify-write (IDLE grant -> RD -> WR) on the single-ported array.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   bus        sf_ctrl_if.slave: req/upd handshakes, array port, lookup
//              results and init_done
module sf_ctrl #(
    parameter int unsigned SET_W  = 7,
    parameter int unsigned TAG_W  = 35,
    parameter int unsigned NUM_RN = 4,
    parameter int unsigned RN_W   = 2
) (
    input  logic    clock,
    input  logic    reset,
    sf_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SET_W-1:0]  cnt_q, cnt_d;
    logic              rr_q, rr_d;          // 0: request side wins next contention
    logic              done_q, done_d;

    // Operation latched at grant time
    logic              op_req_q;
    logic              flag_q;              // unique (request) or inval (update)
    logic [SET_W-1:0]  set_q;
    logic [TAG_W-1:0]  tag_q;
    logic [RN_W-1:0]   src_q;

    logic              load;
    logic              load_req;

    logic              req_ready;
    logic              upd_ready;
    logic              arr_en;
    logic              arr_we;
    logic [SET_W-1:0]  arr_set;
    logic [TAG_W-1:0]  arr_wtag;
    logic [NUM_RN-1:0] arr_wvec;
    logic              lkp_valid;
    logic              lkp_hit;
    logic [NUM_RN-1:0] lkp_snp_vec;
    logic              lkp_evict;
    logic [TAG_W-1:0]  lkp_evict_tag;
    logic [NUM_RN-1:0] lkp_evict_vec;

    // Read-data qualifiers for the WR step
    logic              tag_match;
    logic              vec_nz;
    logic [NUM_RN-1:0] src_bit;

    assign tag_match = (bus.arr_rtag == tag_q);
    assign vec_nz    = |bus.arr_rvec;
    assign src_bit   = NUM_RN'(1) << src_q;

    // State and latched-operation registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
        end
    end

    // Operation fields carry no reset: they are only consumed after a grant
    always_ff @(posedge clock) begin
        if (load) begin
            op_req_q <= load_req;
            if (load_req) begin
                flag_q <= bus.req_unique;
                set_q  <= bus.req_set;
                tag_q  <= bus.req_tag;
                src_q  <= bus.req_src;
            end else begin
                flag_q <= bus.upd_inval;
                set_q  <= bus.upd_set;
                tag_q  <= bus.upd_tag;
                src_q  <= bus.upd_src;
            end
        end
    end

    // Next-state, grant and array/lookup output decode
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rr_d          = rr_q;
        done_d        = done_q;
        load          = 1'b0;
        load_req      = 1'b0;
        req_ready     = 1'b0;
        upd_ready     = 1'b0;
        arr_en        = 1'b0;
        arr_we        = 1'b0;
        arr_set       = '0;
        arr_wtag      = '0;
        arr_wvec      = '0;
        lkp_valid     = 1'b0;
        lkp_hit       = 1'b0;
        lkp_snp_vec   = '0;
        lkp_evict     = 1'b0;
        lkp_evict_tag = '0;
        lkp_evict_vec = '0;

        case (state_q)
            INIT: begin
                arr_en  = 1'b1;
                arr_we  = 1'b1;
                arr_set = cnt_q;
                cnt_d   = cnt_q + SET_W'(1);
                if (&cnt_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            IDLE: begin
                // rr only matters, and only flips, when both sides contend
                if (bus.req_valid && (!bus.upd_valid || !rr_q)) begin
                    req_ready = 1'b1;
                    load      = 1'b1;
                    load_req  = 1'b1;
                    state_d   = RD;
                    if (bus.upd_valid) begin
                        rr_d = 1'b1;
                    end
                end else if (bus.upd_valid) begin
                    upd_ready = 1'b1;
                    load      = 1'b1;
                    state_d   = RD;
                    if (bus.req_valid) begin
                        rr_d = 1'b0;
                    end
                end
            end

            RD: begin
                arr_en  = 1'b1;
                arr_set = set_q;
                state_d = WR;
            end

            WR: begin
                state_d = IDLE;
                arr_set = set_q;
                if (op_req_q) begin
                    arr_en    = 1'b1;
                    arr_we    = 1'b1;
                    lkp_valid = 1'b1;
                    arr_wtag  = tag_q;
                    if (tag_match && vec_nz) begin
                        lkp_hit     = 1'b1;
                        lkp_snp_vec = bus.arr_rvec & ~src_bit;
                        arr_wvec    = flag_q ? src_bit : (bus.arr_rvec | src_bit);
                    end else begin
                        // Miss: entry is reallocated to the requester
                        arr_wvec = src_bit;
                        if (!tag_match && vec_nz) begin
                            lkp_evict     = 1'b1;
                            lkp_evict_tag = bus.arr_rtag;
                            lkp_evict_vec = bus.arr_rvec;
                        end
                    end
                end else if (tag_match) begin
                    arr_en   = 1'b1;
                    arr_we   = 1'b1;
                    arr_wtag = tag_q;
                    arr_wvec = flag_q ? (bus.arr_rvec & ~src_bit) : (bus.arr_rvec | src_bit);
                end
                // Update against a replaced tag is stale and dropped
            end

            default: begin
                state_d = INIT;
            end
        endcase

        // An in-flight operation is abandoned the moment reset is seen
        if (reset) begin
            load        = 1'b0;
            req_ready   = 1'b0;
            upd_ready   = 1'b0;
            arr_en      = 1'b0;
            arr_we      = 1'b0;
            lkp_valid   = 1'b0;
            lkp_hit     = 1'b0;
            lkp_snp_vec = '0;
            lkp_evict   = 1'b0;
            lkp_evict_tag = '0;
            lkp_evict_vec = '0;
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.upd_ready     = upd_ready;
    assign bus.arr_en        = arr_en;
    assign bus.arr_we        = arr_we;
    assign bus.arr_set       = arr_set;
    assign bus.arr_wtag      = arr_wtag;
    assign bus.arr_wvec      = arr_wvec;
    assign bus.lkp_valid     = lkp_valid;
    assign bus.lkp_hit       = lkp_hit;
    assign bus.lkp_snp_vec   = lkp_snp_vec;
    assign bus.lkp_evict     = lkp_evict;
    assign bus.lkp_evict_tag = lkp_evict_tag;
    assign bus.lkp_evict_vec = lkp_evict_vec;
    assign bus.init_done     = done_q;

endmodule
